// File: rtl/breceive_pkg.sv
// Shared constants and state encoding for the toggle-handshake receiver.
`timescale 1ns/100ps
package breceive_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int CNT_W           = 16;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_VALID = 1'b1;

endpackage

// File: rtl/breceive_fsm_bsync.sv
// Multi-flop synchronizer for a single-bit level crossing into the receive clock.
`timescale 1ns/100ps
module bsync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0;
    end else begin
      s <= {s[STAGES-2:0], d};
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/breceive_fsm.sv
// Receive side of a toggle request/acknowledge clock-domain crossing: captures one
// word per request toggle, holds it until consumed, and toggles the acknowledge.
`timescale 1ns/100ps
module breceive_fsm
  import breceive_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             bclk,
  input  logic             brst,
  input  logic             areq_tgl,
  input  logic [WIDTH-1:0] adata,
  output logic [WIDTH-1:0] bdata,
  output logic             bvalid,
  input  logic             bload,
  output logic             back_tgl,
  output logic             berr,
  input  logic             bclr_err,
  output logic [CNT_W-1:0] bcnt
);

  state_t state;
  logic   req_sync;
  logic   req_hist;
  logic   req_edge;
  logic   overrun;

  bsync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (bclk),
    .rst (brst),
    .d   (areq_tgl),
    .q   (req_sync)
  );

  assign req_edge = req_sync ^ req_hist;
  assign bvalid   = (state == ST_VALID);
  // A request arriving while a word is still held (even in its consume cycle) is lost.
  assign overrun  = bvalid & req_edge;

  always_ff @(posedge bclk or posedge brst) begin
    if (brst) begin
      state    <= ST_IDLE;
      req_hist <= 1'b0;
      bdata    <= '0;
      back_tgl <= 1'b0;
      berr     <= 1'b0;
      bcnt     <= '0;
    end else begin
      req_hist <= req_sync;
      case (state)
        ST_IDLE: begin
          if (req_edge) begin
            bdata <= adata;
            state <= ST_VALID;
          end
        end
        default: begin
          if (bload) begin
            state    <= ST_IDLE;
            back_tgl <= ~back_tgl;
            bcnt     <= bcnt + 1'b1;
          end
        end
      endcase
      // Setting wins over a simultaneous clear.
      if (overrun) begin
        berr <= 1'b1;
      end else if (bclr_err) begin
        berr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_breceive_fsm.sv
// Scoreboard bench for breceive_fsm: directed handshake cases plus randomised
// round trips against a behavioural sender on an unrelated clock.
`timescale 1ns/100ps
module tb_breceive_fsm;

  logic        bclk = 1'b0;
  logic        aclk = 1'b0;
  int          bhalf = 5;
  int          ahalf = 3;

  logic        brst;
  logic        areq_tgl;
  logic [7:0]  adata;
  logic [7:0]  bdata;
  logic        bvalid;
  logic        bload;
  logic        back_tgl;
  logic        berr;
  logic        bclr_err;
  logic [15:0] bcnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];

  bit          auto_en  = 1'b0;
  bit          snd_en   = 1'b0;
  int          snd_left = 0;
  logic        ack_s1   = 1'b0;
  logic        ack_s2   = 1'b0;

  breceive_fsm #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .bclk     (bclk),
    .brst     (brst),
    .areq_tgl (areq_tgl),
    .adata    (adata),
    .bdata    (bdata),
    .bvalid   (bvalid),
    .bload    (bload),
    .back_tgl (back_tgl),
    .berr     (berr),
    .bclr_err (bclr_err),
    .bcnt     (bcnt)
  );

  initial forever #(bhalf) bclk = ~bclk;

  // Fractional offset keeps aclk edges off every bclk edge and stimulus instant.
  initial begin
    #0.3;
    forever #(ahalf) aclk = ~aclk;
  end

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    adata    = w;
    areq_tgl = ~areq_tgl;
    exp_q.push_back(w);
  endtask

  // Monitor: every word taken by the consumer is checked against the scoreboard.
  initial forever begin
    logic [7:0] exp_v;
    @(negedge bclk);
    if (brst === 1'b0 && bvalid === 1'b1 && bload === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word_order: got %0h expected no word", bdata);
      end else begin
        exp_v = exp_q.pop_front();
        if (bdata !== exp_v) begin
          n_fail++;
          $display("FAIL word_data: got %0h expected %0h", bdata, exp_v);
        end
      end
    end
  end

  // Behavioural sender: new word only once the acknowledge has caught up.
  initial forever begin
    logic [7:0] w;
    @(posedge aclk);
    ack_s2 = ack_s1;
    ack_s1 = back_tgl;
    if (snd_en && snd_left > 0 && ack_s2 == areq_tgl) begin
      w        = 8'($urandom);
      adata    = w;
      areq_tgl = ~areq_tgl;
      exp_q.push_back(w);
      snd_left--;
    end
  end

  // Random-stall consumer for the round-trip runs.
  initial forever begin
    @(posedge bclk);
    #2;
    if (auto_en) bload = ($urandom_range(0, 3) != 0);
  end

  task automatic run_phase(input string name, input int bh, input int ah);
    int cyc;
    brst     = 1'b1;
    areq_tgl = 1'b0;
    bload    = 1'b0;
    bclr_err = 1'b0;
    ack_s1   = 1'b0;
    ack_s2   = 1'b0;
    bhalf    = bh;
    ahalf    = ah;
    repeat (3) tick();
    brst = 1'b0;
    tick();
    snd_left = 1000;
    snd_en   = 1'b1;
    auto_en  = 1'b1;
    cyc = 0;
    while ((snd_left > 0 || exp_q.size() > 0 || bvalid) && cyc < 40000) begin
      tick();
      cyc++;
    end
    snd_en  = 1'b0;
    auto_en = 1'b0;
    bload   = 1'b0;
    check({name, "_pending"}, 32'(snd_left + exp_q.size()), 0);
    repeat (2) tick();
    check({name, "_bcnt"}, 32'(bcnt), 1000);
    check({name, "_berr"}, 32'(berr), 0);
    check({name, "_bvalid"}, 32'(bvalid), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    brst     = 1'b1;
    areq_tgl = 1'b0;
    adata    = 8'h00;
    bload    = 1'b0;
    bclr_err = 1'b0;
    repeat (3) tick();
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_bdata", 32'(bdata), 0);
    check("rst_back", 32'(back_tgl), 0);
    check("rst_berr", 32'(berr), 0);
    check("rst_bcnt", 32'(bcnt), 0);
    brst = 1'b0;
    tick();

    // Single word: valid after the third rising edge.
    send_word(8'hA5);
    tick();
    tick();
    check("lat_early", 32'(bvalid), 0);
    tick();
    check("lat_valid", 32'(bvalid), 1);
    check("cap_bdata", 32'(bdata), 32'hA5);

    // Stall with changing adata.
    adata = 8'h00;
    repeat (20) tick();
    check("stall_bdata", 32'(bdata), 32'hA5);
    check("stall_bvalid", 32'(bvalid), 1);
    check("stall_back", 32'(back_tgl), 0);

    // Overrun while holding.
    areq_tgl = ~areq_tgl;
    repeat (4) tick();
    check("ovr_berr", 32'(berr), 1);
    check("ovr_bdata", 32'(bdata), 32'hA5);
    check("ovr_back", 32'(back_tgl), 0);
    check("ovr_bvalid", 32'(bvalid), 1);
    bclr_err = 1'b1;
    tick();
    bclr_err = 1'b0;
    check("clr_berr", 32'(berr), 0);

    bload = 1'b1;
    tick();
    bload = 1'b0;
    check("cons_bvalid", 32'(bvalid), 0);
    check("cons_back", 32'(back_tgl), 1);
    check("cons_bcnt", 32'(bcnt), 1);

    // Overrun landing on the consume cycle, with a simultaneous clear.
    send_word(8'h3C);
    repeat (3) tick();
    check("v2_bvalid", 32'(bvalid), 1);
    areq_tgl = ~areq_tgl;
    tick();
    tick();
    bload    = 1'b1;
    bclr_err = 1'b1;
    tick();
    bload    = 1'b0;
    bclr_err = 1'b0;
    check("co_bvalid", 32'(bvalid), 0);
    check("co_berr", 32'(berr), 1);
    check("co_back", 32'(back_tgl), 0);
    check("co_bcnt", 32'(bcnt), 2);
    repeat (5) tick();
    check("drop_bvalid", 32'(bvalid), 0);
    bclr_err = 1'b1;
    tick();
    bclr_err = 1'b0;
    check("clr2_berr", 32'(berr), 0);

    // bload in IDLE does nothing.
    bload = 1'b1;
    repeat (3) tick();
    bload = 1'b0;
    check("idle_bcnt", 32'(bcnt), 2);
    check("idle_back", 32'(back_tgl), 0);

    // Counter wrap from 0xFFFF.
    send_word(8'h5A);
    repeat (3) tick();
    check("wrap_bvalid", 32'(bvalid), 1);
    force dut.bcnt = 16'hFFFF;
    #1;
    release dut.bcnt;
    bload = 1'b1;
    tick();
    bload = 1'b0;
    check("wrap_bcnt", 32'(bcnt), 0);
    check("wrap_back", 32'(back_tgl), 1);

    // Asynchronous reset while a word is held and berr is set.
    send_word(8'h77);
    repeat (3) tick();
    check("rmo_pre_bvalid", 32'(bvalid), 1);
    areq_tgl = ~areq_tgl;
    repeat (3) tick();
    check("rmo_pre_berr", 32'(berr), 1);
    #1;
    brst = 1'b1;
    #1;
    check("rmo_bvalid", 32'(bvalid), 0);
    check("rmo_back", 32'(back_tgl), 0);
    check("rmo_bcnt", 32'(bcnt), 0);
    check("rmo_berr", 32'(berr), 0);
    exp_q.delete();
    areq_tgl = 1'b0;
    adata    = 8'h00;
    tick();
    tick();
    brst = 1'b0;
    repeat (10) tick();
    check("rel_back", 32'(back_tgl), 0);
    check("rel_bvalid", 32'(bvalid), 0);

    // Request already high at reset release yields exactly one word.
    brst     = 1'b1;
    adata    = 8'h99;
    areq_tgl = 1'b1;
    exp_q.push_back(8'h99);
    tick();
    brst = 1'b0;
    tick();
    tick();
    check("hi_rel_early", 32'(bvalid), 0);
    tick();
    check("hi_rel_bvalid", 32'(bvalid), 1);
    check("hi_rel_bdata", 32'(bdata), 32'h99);
    bload = 1'b1;
    tick();
    bload = 1'b0;
    check("hi_rel_back", 32'(back_tgl), 1);
    check("hi_rel_bcnt", 32'(bcnt), 1);
    repeat (5) tick();
    check("hi_rel_once", 32'(bvalid), 0);

    run_phase("rt_3_7", 7, 3);
    run_phase("rt_7_3", 3, 7);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
